// File: rtl/fft_pkg.sv
// Shared constants, state encoding and table-slicing helpers for the
// twiddle coefficient sequencer.
package fft_pkg;

    localparam int NBITS  = 11;
    localparam int N      = 32;
    localparam int W      = 2 * NBITS;
    localparam int PAR    = 4;
    localparam int BEATS  = N / PAR;
    localparam int FCNT_W = 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest bit of table word k inside the packed coefficient bus.
    function automatic int word_lo(input int k);
        return k * W;
    endfunction

    // Highest bit of table word k inside the packed coefficient bus.
    function automatic int word_hi(input int k);
        return (k + 1) * W - 1;
    endfunction

endpackage

// File: rtl/twiddle_sched_if.sv
// Coefficient stream from the sequencer to the butterfly lanes:
// valid/ready handshake carrying PAR words, the beat index and a frame-end flag.
interface twiddle_sched_if;
    import fft_pkg::*;

    logic [PAR*W-1:0]  tw_data;
    logic              tw_valid;
    logic              tw_ready;
    logic [BEAT_W-1:0] tw_beat;
    logic              tw_last;

    modport master (
        output tw_data,
        output tw_valid,
        output tw_beat,
        output tw_last,
        input  tw_ready
    );

    modport slave (
        input  tw_data,
        input  tw_valid,
        input  tw_beat,
        input  tw_last,
        output tw_ready
    );

endinterface

// File: rtl/coeff_lane_mux.sv
// Selects the PAR consecutive table words that form one output beat.
// Lane j carries word beat*PAR + j; N is assumed to be a multiple of PAR.
module coeff_lane_mux
    import fft_pkg::*;
(
    input  logic [N*W-1:0]    coeff_data,
    input  logic [BEAT_W-1:0] beat,
    output logic [PAR*W-1:0]  lanes
);

    // Gather the words of the requested beat into the lane positions
    always_comb begin
        lanes = '0;
        for (int j = 0; j < PAR; j++) begin
            lanes[j*W +: W] = coeff_data[word_lo(int'(beat) * PAR + j) +: W];
        end
    end

endmodule

// File: rtl/twiddle_sched.sv
// Frame sequencer: streams the coefficient table beat by beat for a
// programmable number of frames, holds under back-pressure and pulses
// done on completion. Abort cancels without a done pulse.
module twiddle_sched
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [N*W-1:0]      coeff_data,
    input  logic                start,
    input  logic [FCNT_W-1:0]   nframes,
    input  logic                abort,
    twiddle_sched_if.master     tw,
    output logic                busy,
    output logic                done
);

    state_t             state;
    logic [FCNT_W-1:0]  frame_cnt;
    logic [FCNT_W-1:0]  frame_tot;
    logic [BEAT_W-1:0]  beat_q;
    logic [BEAT_W-1:0]  beat_inc;
    logic [BEAT_W-1:0]  mux_beat;
    logic [PAR*W-1:0]   data_q;
    logic [PAR*W-1:0]   mux_lanes;
    logic               valid_q;
    logic               last_q;
    logic               accept;
    logic               final_beat;
    logic               last_frame;

    assign accept     = valid_q & tw.tw_ready;
    assign final_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign last_frame = (frame_cnt == frame_tot - FCNT_W'(1));
    assign beat_inc   = final_beat ? '0 : beat_q + BEAT_W'(1);

    // The mux looks one beat ahead so the data register can load on accept;
    // from IDLE the first beat is always beat 0.
    assign mux_beat   = (state == RUN) ? beat_inc : '0;

    coeff_lane_mux u_lane_mux (
        .coeff_data (coeff_data),
        .beat       (mux_beat),
        .lanes      (mux_lanes)
    );

    assign tw.tw_data  = data_q;
    assign tw.tw_valid = valid_q;
    assign tw.tw_beat  = beat_q;
    assign tw.tw_last  = last_q;

    // Sequencing FSM with every output registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            frame_tot <= '0;
            beat_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        busy <= 1'b1;
                        if (nframes != '0) begin
                            state     <= RUN;
                            frame_tot <= nframes;
                            frame_cnt <= '0;
                            beat_q    <= '0;
                            data_q    <= mux_lanes;
                            valid_q   <= 1'b1;
                            last_q    <= (BEATS == 1);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        beat_q  <= '0;
                        busy    <= 1'b0;
                    end else if (accept) begin
                        if (final_beat && last_frame) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            beat_q  <= '0;
                            done    <= 1'b1;
                        end else begin
                            beat_q <= beat_inc;
                            data_q <= mux_lanes;
                            last_q <= (beat_inc == BEAT_W'(BEATS - 1));
                            if (final_beat) begin
                                frame_cnt <= frame_cnt + FCNT_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twiddle_sched.sv
// Randomized bench for twiddle_sched: expected beats come from a queue
// built frame by frame from the coefficient table held here.
module tb_twiddle_sched;
    import fft_pkg::*;

    logic                clk;
    logic                rst;
    logic [N*W-1:0]      coeff_data;
    logic                start;
    logic [FCNT_W-1:0]   nframes;
    logic                abort;
    logic                busy;
    logic                done;

    int unsigned table_w [N];
    int vectors;
    int miscompares;

    twiddle_sched_if tw_if ();

    twiddle_sched dut (
        .clk        (clk),
        .rst        (rst),
        .coeff_data (coeff_data),
        .start      (start),
        .nframes    (nframes),
        .abort      (abort),
        .tw         (tw_if),
        .busy       (busy),
        .done       (done)
    );

    logic [PAR*W+BEAT_W+3:0] outs;
    assign outs = {tw_if.tw_data, tw_if.tw_beat, tw_if.tw_valid, tw_if.tw_last, busy, done};

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input bit rnd);
        for (int k = 0; k < N; k++) begin
            table_w[k] = rnd ? $urandom_range(0, (1 << W) - 1) : k;
            coeff_data[k*W +: W] = W'(table_w[k]);
        end
    endtask

    function automatic logic [PAR*W-1:0] exp_lanes(input int b);
        logic [PAR*W-1:0] r;
        for (int j = 0; j < PAR; j++) begin
            r[j*W +: W] = W'(table_w[b*PAR + j]);
        end
        return r;
    endfunction

    task automatic drive_start(input int nf);
        start   = 1'b1;
        nframes = FCNT_W'(nf);
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: outputs=%0h expected 0", outs);
        end
        tw_if.tw_ready = 1'b1;
        drive_start(2);
        step();
        step();
        vectors++;
        if (tw_if.tw_valid !== 1'b1 || tw_if.tw_beat !== BEAT_W'(2)) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_run: valid=%b beat=%0d expected valid=1 beat=2",
                     tw_if.tw_valid, tw_if.tw_beat);
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: outputs=%0h expected 0", outs);
        end
        step();
        #2 rst = 1'b0;
        step();
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: outputs=%0h expected 0", outs);
        end
        tw_if.tw_ready = 1'b0;
    endtask

    task automatic test_single_frame();
        tw_if.tw_ready = 1'b1;
        drive_start(1);
        for (int i = 0; i < BEATS; i++) begin
            vectors++;
            if ({tw_if.tw_valid, tw_if.tw_beat, tw_if.tw_last, done} !==
                {1'b1, BEAT_W'(i), (i == BEATS - 1), 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL single_ctrl[%0d]: valid=%b beat=%0d last=%b done=%b expected 1 %0d %b 0",
                         i, tw_if.tw_valid, tw_if.tw_beat, tw_if.tw_last, done, i, (i == BEATS - 1));
            end
            vectors++;
            if (tw_if.tw_data !== exp_lanes(i)) begin
                miscompares++;
                $display("[TB] FAIL single_data[%0d]: got %0h expected %0h", i, tw_if.tw_data, exp_lanes(i));
            end
            step();
        end
        vectors++;
        if ({tw_if.tw_valid, done, busy} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL single_done: valid/done/busy=%b expected 011", {tw_if.tw_valid, done, busy});
        end
        step();
        vectors++;
        if ({tw_if.tw_valid, done, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL single_idle: valid/done/busy=%b expected 000", {tw_if.tw_valid, done, busy});
        end
    endtask

    task automatic test_back_pressure();
        int accepts = 0;
        int e = 0;
        int stalls = 0;
        tw_if.tw_ready = 1'b1;
        drive_start(1);
        for (int cyc = 0; cyc < 40 && accepts < BEATS; cyc++) begin
            if (tw_if.tw_valid) begin
                vectors++;
                if (tw_if.tw_beat !== BEAT_W'(e) || tw_if.tw_data !== exp_lanes(e)) begin
                    miscompares++;
                    $display("[TB] FAIL bp_beat: beat=%0d data=%0h expected beat=%0d data=%0h",
                             tw_if.tw_beat, tw_if.tw_data, e, exp_lanes(e));
                end
            end
            if (tw_if.tw_valid && tw_if.tw_beat == BEAT_W'(2) && stalls < 3) begin
                tw_if.tw_ready = 1'b0;
                stalls++;
            end else begin
                tw_if.tw_ready = 1'b1;
            end
            if (tw_if.tw_valid && tw_if.tw_ready) begin
                accepts++;
                e++;
            end
            step();
        end
        vectors++;
        if (accepts != BEATS) begin
            miscompares++;
            $display("[TB] FAIL bp_accepts: got %0d expected %0d", accepts, BEATS);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_done: got %b expected 1", done);
        end
        step();
    endtask

    task automatic test_multi_frame(input int nf, input string tag);
        int exp_q[$];
        int accepts = 0;
        int lasts = 0;
        int wraps = 0;
        int dones = 0;
        int extra = 0;
        int prev = -1;
        for (int f = 0; f < nf; f++) begin
            for (int b = 0; b < BEATS; b++) exp_q.push_back(b);
        end
        drive_start(nf);
        for (int cyc = 0; cyc < 100 * nf && exp_q.size() > 0; cyc++) begin
            if (done) dones++;
            tw_if.tw_ready = 1'($urandom_range(0, 1));
            if (tw_if.tw_valid) begin
                vectors++;
                if (tw_if.tw_beat !== BEAT_W'(exp_q[0]) || tw_if.tw_data !== exp_lanes(exp_q[0]) ||
                    tw_if.tw_last !== (exp_q[0] == BEATS - 1)) begin
                    miscompares++;
                    $display("[TB] FAIL %s_beat: beat=%0d last=%b data=%0h expected beat=%0d data=%0h",
                             tag, tw_if.tw_beat, tw_if.tw_last, tw_if.tw_data, exp_q[0], exp_lanes(exp_q[0]));
                end
                if (tw_if.tw_ready) begin
                    if (tw_if.tw_last) lasts++;
                    if (prev == BEATS - 1 && tw_if.tw_beat == '0) wraps++;
                    prev = int'(tw_if.tw_beat);
                    accepts++;
                    void'(exp_q.pop_front());
                end
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            if (done) dones++;
            if (tw_if.tw_valid) extra++;
            step();
        end
        vectors++;
        if (accepts != nf * BEATS || extra != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_accepts: got %0d (+%0d trailing valid) expected %0d", tag, accepts, extra, nf * BEATS);
        end
        vectors++;
        if (wraps != nf - 1 || lasts != nf) begin
            miscompares++;
            $display("[TB] FAIL %s_frames: wraps=%0d lasts=%0d expected %0d %0d", tag, wraps, lasts, nf - 1, nf);
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("[TB] FAIL %s_done_count: got %0d expected 1", tag, dones);
        end
    endtask

    task automatic test_zero_frames();
        drive_start(0);
        vectors++;
        if ({tw_if.tw_valid, done, busy} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL zero_done: valid/done/busy=%b expected 011", {tw_if.tw_valid, done, busy});
        end
        step();
        vectors++;
        if ({tw_if.tw_valid, done, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL zero_idle: valid/done/busy=%b expected 000", {tw_if.tw_valid, done, busy});
        end
    endtask

    task automatic test_ignored_start();
        tw_if.tw_ready = 1'b1;
        drive_start(2);
        for (int i = 0; i < 2 * BEATS; i++) begin
            vectors++;
            if (tw_if.tw_valid !== 1'b1 || tw_if.tw_beat !== BEAT_W'(i % BEATS) ||
                tw_if.tw_data !== exp_lanes(i % BEATS)) begin
                miscompares++;
                $display("[TB] FAIL ign_beat[%0d]: valid=%b beat=%0d expected 1 %0d",
                         i, tw_if.tw_valid, tw_if.tw_beat, i % BEATS);
            end
            start   = (i == 3);
            nframes = FCNT_W'(5);
            step();
        end
        start = 1'b0;
        vectors++;
        if ({tw_if.tw_valid, done} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL ign_done: valid/done=%b expected 01", {tw_if.tw_valid, done});
        end
        start   = 1'b1;
        nframes = FCNT_W'(1);
        step();
        start   = 1'b0;
        vectors++;
        if ({tw_if.tw_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL done_start_ignored: valid/busy=%b expected 00", {tw_if.tw_valid, busy});
        end
    endtask

    task automatic test_abort();
        int late_done = 0;
        tw_if.tw_ready = 1'b1;
        drive_start(1);
        for (int cyc = 0; cyc < 20 && !(tw_if.tw_valid && tw_if.tw_beat == BEAT_W'(4)); cyc++) step();
        tw_if.tw_ready = 1'b0;
        vectors++;
        if (tw_if.tw_valid !== 1'b1 || tw_if.tw_beat !== BEAT_W'(4)) begin
            miscompares++;
            $display("[TB] FAIL abort_reach: valid=%b beat=%0d expected 1 4", tw_if.tw_valid, tw_if.tw_beat);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({tw_if.tw_valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: valid/busy/done=%b expected 000", {tw_if.tw_valid, busy, done});
        end
        for (int i = 0; i < 3; i++) begin
            if (done || tw_if.tw_valid) late_done++;
            step();
        end
        vectors++;
        if (late_done != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", late_done);
        end
        drive_start(1);
        vectors++;
        if (tw_if.tw_valid !== 1'b1 || tw_if.tw_beat !== '0 || tw_if.tw_data !== exp_lanes(0)) begin
            miscompares++;
            $display("[TB] FAIL abort_restart: valid=%b beat=%0d data=%0h expected 1 0 %0h",
                     tw_if.tw_valid, tw_if.tw_beat, tw_if.tw_data, exp_lanes(0));
        end
        tw_if.tw_ready = 1'b1;
        for (int i = 0; i <= BEATS; i++) step();
    endtask

    task automatic test_max_frames();
        int accepts = 0;
        bit seen = 1'b0;
        tw_if.tw_ready = 1'b1;
        drive_start((1 << FCNT_W) - 1);
        for (int cyc = 0; cyc < 2300; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (tw_if.tw_valid) accepts++;
            step();
        end
        vectors++;
        if (!seen || accepts != ((1 << FCNT_W) - 1) * BEATS) begin
            miscompares++;
            $display("[TB] FAIL max_frames: done_seen=%b accepts=%0d expected 1 %0d",
                     seen, accepts, ((1 << FCNT_W) - 1) * BEATS);
        end
        step();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        nframes = '0;
        tw_if.tw_ready = 1'b0;
        vectors = 0;
        miscompares = 0;
        load_table(1'b0);
        step();
        step();
        rst = 1'b0;
        step();

        test_reset();
        test_single_frame();
        test_back_pressure();
        test_multi_frame(3, "multi");
        test_zero_frames();
        test_ignored_start();
        test_abort();
        test_max_frames();
        load_table(1'b1);
        for (int it = 0; it < 3; it++) begin
            test_multi_frame(int'($urandom_range(1, 4)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/twiddle_sched.md
Name: twiddle_sched

Overview:
Frame-level sequencer for the static FFT twiddle coefficient bank (packed N-word complex table, 2*NBITS bits per word). On start it streams the table to the parallel butterfly array, PAR coefficients per beat, for a programmable number of frames, using a valid/ready handshake. It sits between the coefficient bank module and the radix-2 butterfly lanes and owns frame sequencing, back-pressure hold and completion signalling.

Parameters:
NBITS, 11, bits per real/imag component; word width W = 2*NBITS (real = upper NBITS, imag = lower NBITS)
N, 32, coefficient words in the table
PAR, 4, coefficients per output beat; N % PAR == 0; BEATS = N/PAR
FCNT_W, 8, width of frame-count input

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
coeff_data  in  N*W  packed table; word k = coeff_data[(k+1)*W-1 : k*W]; must be stable while busy
start  in  1  begin sequence; honoured only in IDLE
nframes  in  FCNT_W  frames to emit; sampled with start
abort  in  1  cancel the current sequence
tw_data  out  PAR*W  lane j = bits [(j+1)*W-1 : j*W] = word beat*PAR + j
tw_valid  out  1  tw_data/tw_beat/tw_last are valid
tw_ready  in  1  consumer accepts the beat
tw_beat  out  clog2(BEATS) (min 1)  beat index within the frame
tw_last  out  1  high with the final beat of each frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (async): state IDLE; tw_data=0, tw_valid=0, tw_beat=0, tw_last=0, busy=0, done=0; frame counter=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: on start with nframes>0, go to RUN, latch nframes, and load beat 0 (tw_valid=1 on the next cycle, latency 1). On start with nframes==0, go to DONE with no beats emitted.
- RUN: the output register updates only on accept (tw_valid & tw_ready). When tw_ready=0, tw_data, tw_beat and tw_last hold stable.
- On accept of a non-final beat: beat+1, wrapping from BEATS-1 to 0 with frame+1. The next beat's data is presented the following cycle, so back-to-back accepts give one beat per cycle.
- On accept of beat BEATS-1 of the last frame: tw_valid=0 next cycle, go to DONE.
- tw_last = (tw_beat == BEATS-1) whenever tw_valid=1; otherwise 0.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Abort:
  - Abort in RUN or DONE: IDLE next cycle, tw_valid=0, no done pulse.
  - Abort has priority over accept and over start in the same cycle.
  - Abort in IDLE alone is a no-op.
- start while busy is ignored and does not queue.
- Frame counter width is FCNT_W; nframes = 2^FCNT_W-1 completes without overflow.
- Reset asserted mid-sequence: immediate return to the reset values; the partial frame is discarded.

Decomposition:
- Shared package fft_pkg holds:
  - NBITS, N, W, PAR, BEATS constants;
  - the state enum {IDLE, RUN, DONE};
  - the word-slice helper function (index k -> bit range).
- One sub-module, coeff_lane_mux: combinational selection of PAR words from coeff_data by beat index. Its output feeds the tw_data register in twiddle_sched.

Test Plan:
All scenarios use N=32, PAR=4 (BEATS=8), coeff_data word k = k.
- Reset: assert rst mid-clock with no edge -> all outputs 0 immediately; they remain 0 after release.
- Single frame: start with nframes=1, tw_ready=1 -> tw_valid high 8 consecutive cycles from 1 cycle after start; beats 0..7; beat 0 lanes = {0,1,2,3}, beat 7 lanes = {28,29,30,31}; tw_last only on beat 7; done pulses the cycle after the last accept; busy low the cycle after done.
- Back-pressure: nframes=1, tw_ready=0 for 3 cycles while beat 2 is presented -> tw_data stays {8,9,10,11} and tw_beat stays 2 for all 3 cycles; no beat is skipped or duplicated; total accepts = 8.
- Multi-frame: nframes=3, tw_ready random 50% -> 24 accepts, tw_beat wraps 7->0 twice, tw_last accepted 3 times, exactly one done.
- Zero frames and ignored start: nframes=0 -> tw_valid never high, done pulses 1 cycle after start. start asserted during RUN -> no effect on the beat sequence.
- Abort: abort while beat 4 is presented with tw_ready=0 -> tw_valid=0 and busy=0 next cycle, no done. A following start with nframes=1 restarts at beat 0 with lanes {0,1,2,3}.
